// File: rtl/bram_read_arb.sv
// bram_read_arb: two-requester read arbiter in front of a synchronous-read
// BRAM with one cycle of read latency. Each accepted request walks
// IDLE -> RD -> CAP -> ACK, giving a fixed three-cycle grant-to-ack latency.
// Optional feature macro: RR_ARB_EN selects round-robin arbitration;
// when undefined, requester 0 has fixed priority.
module bram_read_arb #(
  parameter int DEPTH = 10,
  parameter int AW    = 4,
  parameter int DW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          busy,
  output logic [AW-1:0] bram_addr,
  input  logic [DW-1:0] bram_data
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    CAP,
    ACK
  } state_t;

  state_t r_state;
  logic   r_owner;   // 1 when requester 1 owns the transaction
  logic   r_bad;     // accepted address was outside 0..DEPTH-1
`ifdef RR_ARB_EN
  logic   r_ptr;     // requester that wins the next tie
`endif

  logic          w_pick1;
  logic [AW-1:0] w_addr;
  logic          w_oob;

  // Arbitration choice and range check of the winning address
  always_comb begin
    w_pick1 = 1'b0;
`ifdef RR_ARB_EN
    w_pick1 = req1 & (~req0 | r_ptr);
`else
    w_pick1 = ~req0;
`endif
    w_addr = w_pick1 ? addr1 : addr0;
    w_oob  = (32'(w_addr) >= 32'(DEPTH));
  end

  // Transaction FSM with registered pulse, data and address outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_owner   <= 1'b0;
      r_bad     <= 1'b0;
`ifdef RR_ARB_EN
      r_ptr     <= 1'b0;
`endif
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      rdata     <= '0;
      bram_addr <= '0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req0 || req1) begin
            r_state <= RD;
            busy    <= 1'b1;
            r_owner <= w_pick1;
            r_bad   <= w_oob;
            gnt0    <= ~w_pick1;
            gnt1    <= w_pick1;
            // Out-of-range reads leave the BRAM address untouched
            if (!w_oob) bram_addr <= w_addr;
`ifdef RR_ARB_EN
            r_ptr   <= ~w_pick1;
`endif
          end
        end
        RD: begin
          r_state <= CAP;
        end
        CAP: begin
          r_state <= ACK;
          rdata   <= r_bad ? '0 : bram_data;
        end
        ACK: begin
          r_state <= IDLE;
          busy    <= 1'b0;
          ack0    <= ~r_owner;
          ack1    <= r_owner;
          err     <= r_bad;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_read_arb.sv
// Randomized scoreboard bench for bram_read_arb. A transaction-level model
// decides grants from sampled requests and queues the expected ack; a
// negedge monitor pops and compares whenever the DUT acks.
module tb_bram_read_arb;
  localparam int DEPTH = 10;
  localparam int AW    = 4;
  localparam int DW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic          gnt0, gnt1, ack0, ack1, err, busy;
  logic [DW-1:0] rdata;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_data;

  bram_read_arb #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .rdata(rdata), .err(err), .busy(busy),
    .bram_addr(bram_addr), .bram_data(bram_data)
  );

  always #5 clk = ~clk;

  // BRAM contents and synchronous read port
  logic [DW-1:0] mem [16];
  always @(posedge clk) bram_data <= mem[bram_addr];

  // Requester drive state
  logic          rq  [2] = '{1'b0, 1'b0};
  logic [AW-1:0] ad  [2] = '{'0, '0};
  logic          act [2] = '{1'b0, 1'b0};
  logic          en  [2] = '{1'b0, 1'b0};
  logic          hold[2] = '{1'b0, 1'b0};
  int            fix [2] = '{-1, -1};
  int unsigned   prob = 0, drop_pct = 0;
  assign req0 = rq[0];  assign addr0 = ad[0];
  assign req1 = rq[1];  assign addr1 = ad[1];

  // Scoreboard
  typedef struct {
    logic          who;
    logic [DW-1:0] data;
    logic          err;
    int unsigned   due;
  } exp_t;
  exp_t q[$];

  int unsigned   cyc = 0;
  int unsigned   m_cnt = 0;      // cycles the arbiter remains occupied
  logic          m_ptr = 1'b0;
  logic          m_gnt0 = 1'b0, m_gnt1 = 1'b0;
  logic [AW-1:0] m_baddr = '0;
  int            n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act_v, exp_v);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_cnt = 0; m_ptr = 1'b0; m_gnt0 = 1'b0; m_gnt1 = 1'b0; m_baddr = '0;
  endtask

  // Reference model: one accepted request every four cycles at most
  always @(posedge clk) begin
    if (rst) model_reset();
    else begin
      cyc++;
      m_gnt0 = 1'b0; m_gnt1 = 1'b0;
      if (m_cnt == 0) begin
        if (req0 || req1) begin
          logic          w;
          logic [AW-1:0] a;
          exp_t          e;
          if (req0 && req1) begin
`ifdef RR_ARB_EN
            w = m_ptr;
`else
            w = 1'b0;
`endif
          end else w = req1;
          a = w ? addr1 : addr0;
          e.who  = w;
          e.err  = (int'(a) >= DEPTH);
          e.data = e.err ? '0 : mem[a];
          e.due  = cyc + 3;
          q.push_back(e);
          if (!e.err) m_baddr = a;
          m_ptr  = ~w;
          m_gnt0 = ~w;
          m_gnt1 = w;
          m_cnt  = 3;
        end
      end else m_cnt--;
    end
  end

  // Monitor
  always @(negedge clk) begin
    chk("gnt0", gnt0, m_gnt0);
    chk("gnt1", gnt1, m_gnt1);
    chk("busy", busy, m_cnt != 0);
    chk("bram_addr", bram_addr, m_baddr);
    if (ack0 || ack1) begin
      if (q.size() == 0) chk("unexpected_ack", {ack1, ack0}, 2'b00);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("ack_owner", {ack1, ack0}, e.who ? 2'b10 : 2'b01);
        chk("ack_cycle", cyc, e.due);
        chk("rdata", rdata, e.data);
        chk("err", err, e.err);
      end
    end else begin
      chk("err_no_ack", err, 1'b0);
      if (q.size() > 0 && q[0].due <= cyc) begin
        chk("missing_ack", {ack1, ack0}, q[0].who ? 2'b10 : 2'b01);
        void'(q.pop_front());
      end
    end
  end

  // Requester driver: hold req until ack unless told to hold or drop early
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        logic a_i;
        a_i = (i == 0) ? ack0 : ack1;
        if (act[i]) begin
          if (!hold[i] && (a_i || $urandom_range(99) < drop_pct)) begin
            rq[i] = 1'b0; act[i] = 1'b0;
          end
        end else if (en[i] && $urandom_range(99) < prob) begin
          ad[i]  = (fix[i] >= 0) ? AW'(fix[i]) : AW'($urandom_range(15));
          rq[i]  = 1'b1;
          act[i] = 1'b1;
        end
      end
    end
  end

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 2; i++) begin rq[i] = 1'b0; act[i] = 1'b0; end
    #1;
    chk("rst_gnt", {gnt1, gnt0}, 2'b00);
    chk("rst_ack", {ack1, ack0}, 2'b00);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdata", rdata, '0);
    chk("rst_bram_addr", bram_addr, '0);
  endtask

  task automatic idle_wait(input int unsigned n);
    for (int i = 0; i < 2; i++) begin en[i] = 1'b0; hold[i] = 1'b0; end
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic seen;
    mem[0] = 4'b1010; mem[1] = 4'b0110; mem[2] = 4'b1100; mem[3] = 4'b0011;
    mem[4] = 4'b1001; mem[5] = 4'b0101; mem[6] = 4'b1110; mem[7] = 4'b0001;
    mem[8] = 4'b1000; mem[9] = 4'b0111;
    for (int i = 10; i < 16; i++) mem[i] = 4'b1111;

    // Reset with both requests already high: requester 0 must win first
    rst = 1'b1;
    @(negedge clk); #2;
    apply_reset();
    ad[0] = 4'd1; ad[1] = 4'd4;
    rq[0] = 1'b1; rq[1] = 1'b1; act[0] = 1'b1; act[1] = 1'b1;
    @(negedge clk); #2 rst = 1'b0;
    @(negedge clk); #1;
    chk("first_grant", {gnt1, gnt0}, 2'b01);
    idle_wait(16);

    // Single legal read from requester 0
    prob = 100; fix[0] = 2; en[0] = 1'b1;
    repeat (6) @(negedge clk);
    idle_wait(8);

    // Out-of-range read from requester 1
    fix[1] = 12; en[1] = 1'b1;
    repeat (6) @(negedge clk);
    idle_wait(8);

    // Both held continuously
    fix[0] = 3; fix[1] = 9; hold[0] = 1'b1; hold[1] = 1'b1;
    en[0] = 1'b1; en[1] = 1'b1;
    repeat (24) @(negedge clk);
    idle_wait(16);

    // Reset while in CAP discards the transaction
    fix[0] = 5; en[0] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = gnt0;
    end
    chk("cap_gnt_seen", gnt0, 1'b1);
    en[0] = 1'b0;
    @(negedge clk); #2;
    apply_reset();
    @(negedge clk); #2 rst = 1'b0;
    idle_wait(6);
    fix[0] = 7; en[0] = 1'b1;
    repeat (6) @(negedge clk);
    idle_wait(8);

    // Randomized traffic
    fix[0] = -1; fix[1] = -1; prob = 30; drop_pct = 2;
    for (int blk = 0; blk < 15; blk++) begin
      for (int i = 0; i < 2; i++) begin
        en[i]   = 1'b1;
        hold[i] = ($urandom_range(3) == 0);
      end
      repeat (100) @(negedge clk);
    end
    drop_pct = 0;
    idle_wait(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bram_read_arb.md
BRAM_READ_ARB -- requirements
Module: bram_read_arb

Interface
REQ-001 SHALL have parameter: DEPTH, 10, number of valid BRAM locations; addresses 0..DEPTH-1 are legal.
REQ-002 SHALL have parameter: AW, 4, address width for requester and BRAM address ports.
REQ-003 SHALL have parameter: DW, 4, data width for BRAM data and read data ports.
REQ-004 SHALL have ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0  in  1  requester 0 read request; held high until ack0.
- addr0  in  AW  requester 0 address; stable while req0 is high.
- req1  in  1  requester 1 read request; held high until ack1.
- addr1  in  AW  requester 1 address; stable while req1 is high.
- gnt0  out  1  one-cycle pulse: requester 0 accepted.
- gnt1  out  1  one-cycle pulse: requester 1 accepted.
- ack0  out  1  one-cycle pulse: rdata/err valid for requester 0.
- ack1  out  1  one-cycle pulse: rdata/err valid for requester 1.
- rdata  out  DW  read data; valid only while ack0 or ack1 is high.
- err  out  1  high with ack when the address was >= DEPTH.
- busy  out  1  high whenever the FSM is not in IDLE.
- bram_addr  out  AW  registered address to the synchronous-read BRAM.
- bram_data  in  DW  BRAM registered output (1-cycle read latency).

Function
REQ-005 SHALL implement FSM states IDLE, RD, CAP, ACK; transitions: IDLE->RD on any req, RD->CAP, CAP->ACK, ACK->IDLE, each unconditional except IDLE.
REQ-006 In IDLE with one req high, SHALL grant that requester: latch owner and address, drive bram_addr, pulse the matching gnt for the next cycle.
REQ-007 In IDLE with both req high, SHALL grant per arbitration policy (REQ-019/REQ-020).
REQ-008 In IDLE with no req, SHALL hold bram_addr at its last value and keep all pulses low.
REQ-009 In CAP, SHALL register bram_data into rdata.
REQ-010 In ACK, SHALL assert exactly one of ack0/ack1, for the owner, for one cycle.
REQ-011 Fixed latency: the edge that samples req (E0) -> gnt high E0..E1 -> ack high E3..E4, i.e. 3 cycles from acceptance to ack; there SHALL be no back-to-back grant, so the next grant can be sampled no earlier than the edge leaving ACK.
REQ-012 An address >= DEPTH SHALL traverse the same states with unchanged latency; ack SHALL carry err=1 and rdata=0, and bram_addr SHALL NOT be updated.
REQ-013 err SHALL be 0 whenever no ack is high.
REQ-014 A req dropped before ack (protocol violation) SHALL NOT abort the transaction; ack SHALL still be issued.
REQ-015 A req that is still high during the ACK cycle SHALL be treated as a new request in IDLE.

Reset
REQ-016 On rst high, SHALL asynchronously force: state IDLE; gnt0, gnt1, ack0, ack1, err, and busy to 0; rdata 0; bram_addr 0; priority pointer to requester 0.
REQ-017 Reset asserted mid-transaction SHALL discard it with no ack.
REQ-018 After rst deasserts, the first possible grant SHALL be at the first clk edge.

Configuration
REQ-019 With RR_ARB_EN defined: round-robin; the pointer SHALL move to the non-granted requester after each grant, so with both requesting, grants alternate 0,1,0,1.
REQ-020 With RR_ARB_EN undefined: fixed priority, requester 0 always wins a tie; the pointer logic SHALL be absent.

Verification (bench pairs block with a 10x4 BRAM holding 0:1010 1:0110 2:1100 3:0011 ... 9:0111)
REQ-021 req0, addr0=2 -> gnt0 pulse at E0, ack0 at E3 with rdata=1100, err=0.
REQ-022 req1, addr1=12 -> ack1 at E3 with err=1, rdata=0000, and bram_addr unchanged.
REQ-023 req0 (addr0=3) and req1 (addr1=9) held continuously -> with RR_ARB_EN: ack0 rdata 0011, then ack1 rdata 0111, alternating; without RR_ARB_EN: only requester 0 is served while req0 is held.
REQ-024 rst pulsed in CAP -> no ack; all outputs 0; busy 0; next req0 is served normally.
REQ-025 Both req issued on the first edge after reset -> requester 0 is granted first in both configurations.
